regfile_ram: RTL and testbench

- Simple dual-port synchronous RAM, 32 words x 16 bits, with one write port and one read port on a single clock.
- Serves as the storage primitive behind the register file. Each 32-bit register bank is built from two instances: a low half and a high half.
- Maps onto an FPGA block RAM (read-first, registered output). Forwarding of same-cycle writes is handled by the enclosing register file, not here.

---
 rtl/regfile_ram.sv | 50 +++++
 tb/tb_regfile_ram.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_ram.sv
// Simple dual-port 32x16 RAM, read-first, registered output; one half of a register bank.
// Optional build macro RAM_ZERO_WORD_EN hardwires address 0 to zero.
module regfile_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] RDATA
);

    // Power-up contents are zero; reset never clears the array.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  wr_en_d;

    always_comb begin
        wr_en_d = write && !reset;
        rdata_d = reset ? '0 : mem_q[raddr];
`ifdef RAM_ZERO_WORD_EN
        if (waddr == '0) begin
            wr_en_d = 1'b0;
        end
        if (raddr == '0) begin
            rdata_d = '0;
        end
`endif
    end

    // Read samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
        if (wr_en_d) begin
            mem_q[waddr] <= WDATA;
        end
    end

    assign RDATA = rdata_q;

endmodule

// File: tb/tb_regfile_ram.sv
// Directed plus randomized bench for regfile_ram against an array-based reference model.
module tb_regfile_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [4:0]  waddr;
    logic [15:0] WDATA;
    logic [4:0]  raddr;
    logic [15:0] RDATA;

    int tests  = 0;
    int failed = 0;

    logic [15:0] ref_mem [32];
    logic [15:0] exp_rdata;

    regfile_ram dut (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .waddr (waddr),
        .WDATA (WDATA),
        .raddr (raddr),
        .RDATA (RDATA)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_read(input logic [4:0] a);
`ifdef RAM_ZERO_WORD_EN
        if (a == 5'd0) return 16'h0000;
`endif
        return ref_mem[a];
    endfunction

    function automatic logic model_wr_ok(input logic [4:0] a);
`ifdef RAM_ZERO_WORD_EN
        return a != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    // Apply current inputs for one edge, update the model, then check RDATA.
    task automatic tick(input string tag);
        if (reset) begin
            exp_rdata = 16'h0000;
        end else begin
            exp_rdata = model_read(raddr);
            if (write && model_wr_ok(waddr)) ref_mem[waddr] = WDATA;
        end
        @(posedge clk);
        #1;
        tests++;
        assert (RDATA === exp_rdata)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, RDATA, exp_rdata);
        end
    endtask

    task automatic set_in(input logic w, input logic [4:0] wa, input logic [15:0] wd,
                          input logic [4:0] ra);
        write = w;
        waddr = wa;
        WDATA = wd;
        raddr = ra;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
        reset = 1'b1;
        set_in(1'b1, 5'd3, 16'hFFFF, 5'd3);
        @(posedge clk);
        #1;

        // Reset: write ignored, RDATA cleared
        tick("reset_hold_1");
        tick("reset_hold_2");
        reset = 1'b0;
        set_in(1'b0, 5'd0, 16'h0000, 5'd3);
        tick("reset_write_ignored");

        // Basic write then read
        set_in(1'b1, 5'd7, 16'hA5A5, 5'd0);
        tick("basic_write");
        set_in(1'b0, 5'd0, 16'h0000, 5'd7);
        tick("basic_read");

        // Read-first collision
        set_in(1'b1, 5'd9, 16'h1111, 5'd1);
        tick("collide_setup");
        set_in(1'b1, 5'd9, 16'h2222, 5'd9);
        tick("collide_old");
        set_in(1'b0, 5'd0, 16'h0000, 5'd9);
        tick("collide_new");

        // Back-to-back writes to the same address
        set_in(1'b1, 5'd11, 16'hAAAA, 5'd2);
        tick("b2b_first");
        set_in(1'b1, 5'd11, 16'hBBBB, 5'd11);
        tick("b2b_read_first");
        set_in(1'b0, 5'd0, 16'h0000, 5'd11);
        tick("b2b_last_wins");

        // Full sweep
        for (int a = 0; a < 32; a++) begin
            set_in(1'b1, 5'(a), 16'(a) * 16'h0101, 5'(31 - a));
            tick("sweep_write");
        end
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 5'd0, 16'h0000, 5'(a));
            tick("sweep_read");
        end
        set_in(1'b0, 5'd0, 16'h0000, 5'd0);
        tick("sweep_tail");

        // Write disable
        set_in(1'b0, 5'd5, 16'hDEAD, 5'd0);
        tick("wr_disable");
        set_in(1'b0, 5'd5, 16'hDEAD, 5'd5);
        tick("wr_disable_read");

        // Address 0 behaviour (zero word when feature enabled)
        set_in(1'b1, 5'd0, 16'hBEEF, 5'd0);
        tick("addr0_write");
        set_in(1'b0, 5'd0, 16'h0000, 5'd0);
        tick("addr0_read");

        // Mid-run reset keeps array contents
        reset = 1'b1;
        set_in(1'b1, 5'd7, 16'h0BAD, 5'd7);
        tick("reset_mid");
        reset = 1'b0;
        set_in(1'b0, 5'd0, 16'h0000, 5'd7);
        tick("reset_mid_keep");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 31) == 0);
            set_in(1'(($urandom_range(0, 3) != 0)), 5'($urandom_range(0, 31)),
                   16'($urandom), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
